// File: rtl/pd_pkg.sv
// Shared constants for the pipeline front end.
package pd_pkg;
    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0100_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] PC_STEP          = 32'd4;
endpackage

// File: rtl/fetch_fifo.sv
// Small registered FIFO holding {pc, inst} pairs between imemory and decode.
// Flush wins over push; a pop in a flush cycle is implicitly absorbed.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;

    assign head = mem[rd_ptr];

    // Storage is cleared on reset so the decode-facing outputs read zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues 1-cycle-latency imemory reads and
// queues returned words for decode, flushing on execute-stage redirects.
module fetch_stage #(
    parameter int              XLEN     = pd_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = pd_pkg::RESET_PC_DEFAULT,
    parameter int              QDEPTH   = 2
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_inst
);
    import pd_pkg::*;

    localparam int CW = $clog2(QDEPTH + 1);

    logic [XLEN-1:0]   fetch_pc, req_pc;
    logic              inflight, kill, push, pop;
    logic [CW-1:0]     count;
    logic [CW:0]       occ;
    logic [2*XLEN-1:0] head;

    assign id_valid  = (count != '0);
    assign pop       = id_valid && id_ready;
    // A response landing in a redirect or kill window belongs to the old path.
    assign push      = inflight && !kill && !redirect;
    assign occ       = {1'b0, count} - (CW+1)'(pop) + (CW+1)'(inflight);
    assign imem_req  = !reset && !redirect && (occ < (CW+1)'(QDEPTH));
    assign imem_addr = fetch_pc;
    assign id_pc     = head[2*XLEN-1:XLEN];
    assign id_inst   = head[XLEN-1:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            kill     <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (redirect) begin
                fetch_pc <= redirect_pc & ~XLEN'(3);
                kill     <= inflight;
            end else begin
                // No request issues during a redirect, so kill only spans one cycle.
                kill <= 1'b0;
                if (imem_req) begin
                    fetch_pc <= fetch_pc + XLEN'(PC_STEP);
                    req_pc   <= fetch_pc;
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (QDEPTH),
        .W     (2*XLEN),
        .CW    (CW)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   ({req_pc, imem_rdata}),
        .head  (head),
        .count (count)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: scoreboard of expected decode handshakes plus timing checks.
module tb_fetch_stage;
    logic        clock, reset;
    logic        imem_req;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_inst;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_pc;
    logic [31:0] prev_addr;

    fetch_stage #(
        .XLEN     (32),
        .RESET_PC (32'h0100_0000),
        .QDEPTH   (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_inst     (id_inst)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // imemory model: word at address A is ~A, returned one cycle after the address.
    initial begin
        imem_rdata = '0;
        prev_addr  = '0;
        forever begin
            @(negedge clock);
            imem_rdata = ~prev_addr;
            prev_addr  = imem_addr;
        end
    end

    // Monitor: every decode handshake must match the next expected PC/word.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clock);
            #3;
            if (!reset && id_valid && id_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_handshake: got pc %h want none", id_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", id_pc, e);
                    chk("sb_inst", id_inst, ~e);
                end
            end
        end
    end

    // Record the handshake this cycle will complete (sequential fetch model), then advance.
    task automatic cyc();
        if (!reset && id_valid && id_ready) begin
            exp_q.push_back(exp_pc);
            exp_pc = exp_pc + 32'd4;
        end
        @(negedge clock);
    endtask

    // Redirect in cycle N; checks N, N+1, N+3 and leaves the bench in N+3 (+1).
    task automatic redir(input logic [31:0] tgt, input logic [31:0] aligned);
        redirect    = 1'b1;
        redirect_pc = tgt;
        #1 chk("redir_req_n", {31'b0, imem_req}, 32'd0);
        cyc();
        redirect = 1'b0;
        exp_pc   = aligned;
        #1 chk("redir_req_n1", {31'b0, imem_req}, 32'd1);
        chk("redir_addr_n1", imem_addr, aligned);
        cyc();
        #1 chk("redir_valid_n2", {31'b0, id_valid}, 32'd0);
        cyc();
        #1 chk("redir_valid_n3", {31'b0, id_valid}, 32'd1);
        chk("redir_pc_n3", id_pc, aligned);
    endtask

    initial begin
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b0;
        exp_pc      = 32'h0100_0000;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_pc", id_pc, 32'd0);
        chk("rst_inst", id_inst, 32'd0);
        @(negedge clock);

        // 1: reset release, consecutive requests, 2-cycle req->valid latency
        reset    = 1'b0;
        id_ready = 1'b1;
        #1 chk("t1_req0", {31'b0, imem_req}, 32'd1);
        chk("t1_addr0", imem_addr, 32'h0100_0000);
        chk("t1_valid0", {31'b0, id_valid}, 32'd0);
        cyc();
        #1 chk("t1_addr1", imem_addr, 32'h0100_0004);
        chk("t1_valid1", {31'b0, id_valid}, 32'd0);
        cyc();
        #1 chk("t1_addr2", imem_addr, 32'h0100_0008);
        chk("t1_valid2", {31'b0, id_valid}, 32'd1);
        chk("t1_pc2", id_pc, 32'h0100_0000);

        // 2: four words accepted, then a 5-cycle stall
        repeat (4) cyc();
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t2_stall_req", {31'b0, imem_req}, 32'd0);
            chk("t2_stall_pc", id_pc, 32'h0100_0010);
            chk("t2_stall_inst", id_inst, ~32'h0100_0010);
            cyc();
        end
        id_ready = 1'b1;
        repeat (4) cyc();

        // 3: redirect with a request in flight
        redir(32'h0100_0100, 32'h0100_0100);
        repeat (3) cyc();

        // 4: misaligned redirect target
        redir(32'h0100_0202, 32'h0100_0200);
        repeat (3) cyc();

        // 5: back-to-back redirects, last one wins
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        cyc();
        redirect_pc = 32'h0000_0300;
        exp_pc      = 32'h0000_0300;
        #1 chk("t5_req_n1", {31'b0, imem_req}, 32'd0);
        chk("t5_valid_n1", {31'b0, id_valid}, 32'd0);
        cyc();
        redirect = 1'b0;
        #1 chk("t5_addr", imem_addr, 32'h0000_0300);
        cyc();
        cyc();
        #1 chk("t5_valid", {31'b0, id_valid}, 32'd1);
        chk("t5_pc", id_pc, 32'h0000_0300);
        repeat (3) cyc();

        // 6: asynchronous reset with the queue full
        id_ready = 1'b0;
        repeat (3) cyc();
        #1 chk("t6_full_valid", {31'b0, id_valid}, 32'd1);
        chk("t6_full_req", {31'b0, imem_req}, 32'd0);
        reset = 1'b1;
        #1 chk("t6_rst_valid", {31'b0, id_valid}, 32'd0);
        chk("t6_rst_pc", id_pc, 32'd0);
        @(negedge clock);
        reset    = 1'b0;
        id_ready = 1'b1;
        exp_pc   = 32'h0100_0000;
        #1 chk("t6_restart_addr", imem_addr, 32'h0100_0000);
        chk("t6_restart_req", {31'b0, imem_req}, 32'd1);
        repeat (4) cyc();

        // 7: PC wraps past the top of the address space
        redir(32'hFFFF_FFF4, 32'hFFFF_FFF4);
        chk("t7_addr_fc", imem_addr, 32'hFFFF_FFFC);
        cyc();
        #1 chk("t7_wrap_addr", imem_addr, 32'h0000_0000);
        chk("t7_wrap_req", {31'b0, imem_req}, 32'd1);
        repeat (5) cyc();
        id_ready = 1'b0;
        repeat (2) cyc();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
